mem_port_arbiter: RTL and testbench

Shares the CPU's single 16-bit memory port between two requesters: instruction fetch, driven from the control unit's fetch phase, and data access, driven from the execute phase for load/store. It arbitrates round-robin, registers the winning request onto the memory port and waits for a variable-latency memory acknowledge. It returns read data with a one-cycle ack pulse and aborts with an error flag if memory does not respond within TIMEOUT cycles.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_timer.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: control-unit phase encoding and memory-port arbiter types.
// Imported by the arbiter top module and its timeout counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    CU_FETCH     = 2'd0,
    CU_DECODE    = 2'd1,
    CU_EXECUTE   = 2'd2,
    CU_WRITEBACK = 2'd3
  } cu_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned ARB_TIMER_W = 8;

  // Round-robin preference: the requester that did not win last time.
  function automatic owner_t rr_winner(input owner_t last_owner);
    rr_winner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Saturating wait counter for the arbiter's BUSY states.
// expired flags the enabled cycle whose increment brings the count up to TIMEOUT.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [ARB_TIMER_W-1:0] LIMIT   = ARB_TIMER_W'(TIMEOUT);
  localparam logic [ARB_TIMER_W-1:0] SAT_MAX = {ARB_TIMER_W{1'b1}};

  logic [ARB_TIMER_W-1:0] count_q;
  logic [ARB_TIMER_W-1:0] count_d;

  always_comb begin
    if (clear) begin
      count_d = {ARB_TIMER_W{1'b0}};
    end else if (enable && (count_q != SAT_MAX)) begin
      count_d = count_q + {{(ARB_TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {ARB_TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_d == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the CPU's single memory port between instruction
// fetch and data access, with registered port outputs and a response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            last_owner_q, last_owner_d;
  owner_t            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    err_d        = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req && (!dm_req || (rr_winner(last_owner_q) == OWN_IF))) begin
          state_d      = BUSY_IF;
          owner_d      = OWN_IF;
          last_owner_d = OWN_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = {DATA_W{1'b0}};
          timer_clr    = 1'b1;
        end else if (dm_req) begin
          state_d      = BUSY_DM;
          owner_d      = OWN_DM;
          last_owner_d = OWN_DM;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we;
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          timer_clr    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        timer_en = 1'b1;
        // A real acknowledge wins over a timeout landing in the same cycle.
        if (mem_ack || timer_expired) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : {DATA_W{1'b0}};
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_ack ? mem_rdata : {DATA_W{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_DM;
      owner_q      <= OWN_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= {DATA_W{1'b0}};
      dm_rdata_q   <= {DATA_W{1'b0}};
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a latency-randomised
// memory model that predicts each completion, and a monitor that checks the acks.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = 16'h0;
  logic [15:0] dm_wdata = 16'h0;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        owner;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        mem_auto = 1'b1;
  int          force_lat = -1;
  logic [15:0] force_rd = 16'h0;
  logic        snap_if = 1'b0;
  logic        snap_dm = 1'b0;
  logic        model_last = 1'b1;
  logic        in_txn = 1'b0;
  logic        exp_who;
  logic [15:0] exp_addr;
  logic        exp_we;
  logic [15:0] exp_rd;
  int          lat;
  int          k;
  int          exp_len;
  logic [15:0] model_if_rdata = 16'h0;
  logic [15:0] model_dm_rdata = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    snap_if = if_req;
    snap_dm = dm_req;
  end

  // Memory model: predicts grant order, length of each transaction and its result.
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
      model_last = 1'b1;
      mem_ack = 1'b0;
    end else if (!mem_auto) begin
      in_txn = 1'b0;
    end else if (mem_req && !in_txn) begin
      if (!snap_if && !snap_dm) check("grant_without_req", 32'(mem_req), 32'd0);
      exp_who = (snap_if && snap_dm) ? ~model_last : snap_dm;
      model_last = exp_who;
      exp_addr = exp_who ? dm_addr : if_addr;
      exp_we = exp_who ? dm_we : 1'b0;
      check("grant_owner", 32'(owner), 32'(exp_who));
      check("grant_addr", 32'(mem_addr), 32'(exp_addr));
      check("grant_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) check("grant_wdata", 32'(mem_wdata), 32'(dm_wdata));
      if (force_lat >= 0) lat = force_lat;
      else lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      exp_rd = (force_lat > 0) ? force_rd : 16'($urandom);
      exp_len = (lat == 0) ? TIMEOUT : lat;
      sb.push_back('{who: exp_who, rdata: (lat == 0) ? 16'h0 : exp_rd, err: (lat == 0)});
      in_txn = 1'b1;
      k = 1;
      mem_ack = (k == lat);
      mem_rdata = (k == lat) ? exp_rd : 16'($urandom);
    end else if (mem_req) begin
      k++;
      check("mem_addr_stable", 32'(mem_addr), 32'(exp_addr));
      check("mem_we_stable", 32'(mem_we), 32'(exp_we));
      mem_ack = (k == lat);
      mem_rdata = (k == lat) ? exp_rd : 16'($urandom);
    end else begin
      if (in_txn) begin
        check("mem_req_cycles", 32'(k), 32'(exp_len));
        in_txn = 1'b0;
      end
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  end

  // Monitor: pops the scoreboard on every ack and checks held read data.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_if_rdata = 16'h0;
      model_dm_rdata = 16'h0;
    end else begin
      if (if_ack && dm_ack) check("ack_overlap", 32'd1, 32'd0);
      if (if_ack || dm_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_who", 32'(dm_ack), 32'(e.who));
          check("ack_err", 32'(err), 32'(e.err));
          check("ack_busy", 32'(busy), 32'd1);
          if (e.who) model_dm_rdata = e.rdata;
          else model_if_rdata = e.rdata;
        end
      end else begin
        check("err_without_ack", 32'(err), 32'd0);
      end
      check("if_rdata", 32'(if_rdata), 32'(model_if_rdata));
      check("dm_rdata", 32'(dm_rdata), 32'(model_dm_rdata));
    end
  end

  task automatic do_if(input logic [15:0] a, output int n);
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack && n < 200);
    check("if_ack_seen", 32'(if_ack), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [15:0] a, input logic [15:0] d, output int n);
    @(posedge clk); #1;
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_ack && n < 200);
    check("dm_ack_seen", 32'(dm_ack), 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    int n;
    int n1;
    int n2;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_acks", 32'({if_ack, dm_ack, err}), 32'd0);
    check("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    check("rst_busy_owner", 32'({busy, owner}), 32'd0);
    #1 rst = 1'b0;

    force_lat = 1;
    force_rd = 16'hA5A5;
    do_if(16'h0010, n);
    check("if_latency", 32'(n), 32'd3);
    check("if_rdata_a5a5", 32'(if_rdata), 32'h0000A5A5);

    force_lat = 4;
    force_rd = 16'h5A5A;
    do_dm(1'b1, 16'h0200, 16'h1234, n);
    check("dm_write_latency", 32'(n), 32'd6);

    force_lat = 0;
    do_dm(1'b0, 16'h0400, 16'h0, n);
    check("dm_timeout_latency", 32'(n), 32'(TIMEOUT + 2));
    check("dm_timeout_rdata", 32'(dm_rdata), 32'd0);

    force_lat = -1;
    fork
      begin
        int m;
        for (int i = 0; i < 40; i++) begin
          do_if(16'($urandom), m);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        int m;
        for (int j = 0; j < 40; j++) begin
          do_dm(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), m);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);

    // Stray acknowledges while idle must not start anything.
    mem_auto = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    repeat (3) @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    @(posedge clk); #1;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 16'h0300;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_owner", 32'(owner), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'({dm_ack, if_ack}), 32'd0);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    mem_auto = 1'b1;
    fork
      do_if(16'h0500, n1);
      do_dm(1'b0, 16'h0600, 16'h0, n2);
      begin
        int w;
        w = 0;
        do begin @(negedge clk); w++; end while (!mem_req && w < 10);
        check("post_rst_first_owner", 32'(owner), 32'd0);
      end
    join
    check("post_rst_order", 32'(n1 < n2), 32'd1);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
